// File: rtl/hdr_pkg.sv
// Shared constants and state encoding for the UART-to-SRAM pixel loader.
package hdr_pkg;

    localparam int         SRAM_AW      = 20;
    localparam int         IMAGE_NUMBER = 4;
    localparam logic [4:0] RX_BASE      = 5'd0;
    localparam logic [4:0] STATUS_BASE  = 5'd8;
    localparam int         RX_OK_BIT    = 7;

    typedef enum logic [2:0] {
        S_SYNC_POLL,
        S_SYNC_READ,
        S_POLL,
        S_READ,
        S_WRITE,
        S_DONE
    } loader_state_e;

endpackage

// File: rtl/avm_read_port.sv
// Single-outstanding Avalon-MM read master: launches one read per request and
// holds it under waitrequest; done_o/data_o are valid in the completing cycle.
module avm_read_port
    import hdr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [4:0]  addr_i,
    output logic [4:0]  avm_address_o,
    output logic        avm_read_o,
    input  logic [31:0] avm_readdata_i,
    input  logic        avm_waitrequest_i,
    output logic        done_o,
    output logic [31:0] data_o
);

    logic       read_q;
    logic [4:0] addr_q;

    // Address and read are frozen while a transfer is outstanding; a new read
    // can only start the cycle after completion, leaving one idle cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_q <= 1'b0;
            addr_q <= STATUS_BASE;
        end else if (read_q) begin
            if (!avm_waitrequest_i) begin
                read_q <= 1'b0;
            end
        end else if (req_i) begin
            read_q <= 1'b1;
            addr_q <= addr_i;
        end
    end

    assign avm_address_o = addr_q;
    assign avm_read_o    = read_q;
    assign done_o        = read_q & ~avm_waitrequest_i;
    assign data_o        = avm_readdata_i;

endmodule

// File: rtl/uart_pixel_loader.sv
// Receives IMG_NUM sync-prefixed images from the UART core and streams each
// pixel byte out with a linear SRAM address and a one-cycle write strobe.
module uart_pixel_loader
    import hdr_pkg::*;
#(
    parameter int         IMG_W     = 320,
    parameter int         IMG_H     = 240,
    parameter int         IMG_NUM   = IMAGE_NUMBER,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic               avm_clk,
    input  logic               avm_rst,
    output logic [4:0]         avm_address,
    output logic               avm_read,
    input  logic [31:0]        avm_readdata,
    input  logic               avm_waitrequest,
    output logic [7:0]         pixel_value,
    output logic [SRAM_AW-1:0] addr_store,
    output logic               store_valid,
    output logic [1:0]         img_idx,
    output logic               store_finish
);

    localparam logic [SRAM_AW-1:0] PIX_LAST  = SRAM_AW'(IMG_W * IMG_H - 1);
    localparam logic [SRAM_AW-1:0] ADDR_LAST = SRAM_AW'(IMG_NUM * IMG_W * IMG_H - 1);

    loader_state_e      state_q;
    logic [SRAM_AW-1:0] cnt_q;
    logic [SRAM_AW-1:0] pix_q;
    logic [7:0]         pixel_q;
    logic [SRAM_AW-1:0] addr_q;
    logic               valid_q;
    logic [1:0]         img_q;
    logic               finish_q;

    logic        rd_req;
    logic [4:0]  rd_addr;
    logic        rd_done;
    logic [31:0] rd_data;
    logic        unused_rd_hi;

    always_comb begin
        rd_req  = 1'b0;
        rd_addr = STATUS_BASE;
        case (state_q)
            S_SYNC_POLL, S_POLL: begin
                rd_req  = 1'b1;
                rd_addr = STATUS_BASE;
            end
            S_SYNC_READ, S_READ: begin
                rd_req  = 1'b1;
                rd_addr = RX_BASE;
            end
            default: ;
        endcase
    end

    avm_read_port u_port (
        .clk_i             (avm_clk),
        .rst_ni            (avm_rst),
        .req_i             (rd_req),
        .addr_i            (rd_addr),
        .avm_address_o     (avm_address),
        .avm_read_o        (avm_read),
        .avm_readdata_i    (avm_readdata),
        .avm_waitrequest_i (avm_waitrequest),
        .done_o            (rd_done),
        .data_o            (rd_data)
    );

    assign unused_rd_hi = ^rd_data[31:8];

    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            state_q  <= S_SYNC_POLL;
            cnt_q    <= '0;
            pix_q    <= '0;
            pixel_q  <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            img_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            case (state_q)
                S_SYNC_POLL: begin
                    if (rd_done && rd_data[RX_OK_BIT]) state_q <= S_SYNC_READ;
                end
                S_SYNC_READ: begin
                    if (rd_done) begin
                        state_q <= (rd_data[7:0] == SYNC_BYTE) ? S_POLL : S_SYNC_POLL;
                    end
                end
                S_POLL: begin
                    if (rd_done && rd_data[RX_OK_BIT]) state_q <= S_READ;
                end
                S_READ: begin
                    if (rd_done) begin
                        pixel_q <= rd_data[7:0];
                        addr_q  <= cnt_q;
                        valid_q <= 1'b1;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    valid_q <= 1'b0;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_LAST) begin
                        finish_q <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (pix_q == PIX_LAST) begin
                        // Each image must be re-armed by its own sync byte.
                        pix_q   <= '0;
                        img_q   <= img_q + 2'd1;
                        state_q <= S_SYNC_POLL;
                    end else begin
                        pix_q   <= pix_q + 1'b1;
                        state_q <= S_POLL;
                    end
                end
                default: state_q <= S_DONE;
            endcase
        end
    end

    assign pixel_value  = pixel_q;
    assign addr_store   = addr_q;
    assign store_valid  = valid_q;
    assign img_idx      = img_q;
    assign store_finish = finish_q;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Bench for uart_pixel_loader: behavioural UART slave with random stalls and a
// byte-stream model that predicts every stored pixel, address and strobe.
module tb_uart_pixel_loader;
    import hdr_pkg::*;

    localparam int IMG_W   = 4;
    localparam int IMG_H   = 2;
    localparam int IMG_NUM = 2;
    localparam int PPI     = IMG_W * IMG_H;
    localparam int TOTAL   = IMG_NUM * PPI;

    logic        avm_clk = 1'b0;
    logic        avm_rst = 1'b0;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic [7:0]  pixel_value;
    logic [19:0] addr_store;
    logic        store_valid;
    logic [1:0]  img_idx;
    logic        store_finish;

    always #5 avm_clk = ~avm_clk;

    uart_pixel_loader #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .IMG_NUM   (IMG_NUM),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .pixel_value     (pixel_value),
        .addr_store      (addr_store),
        .store_valid     (store_valid),
        .img_idx         (img_idx),
        .store_finish    (store_finish)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0]  rx_q[$];   // {is_pixel, byte} as the UART will deliver it
    logic [27:0] exp_q[$];  // {addr, pixel} expected SRAM writes in order

    int         notready_left = 0;
    int         force_rx_skip = -1;
    int         wait_left     = 0;
    bit         in_xfer       = 1'b0;
    logic [4:0] xfer_addr     = '0;
    bit         sv_exp        = 1'b0;
    bit         fin_exp       = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART slave and output monitor share one negedge process so the
    // strobe prediction made on a completing RX read is ordered correctly.
    always @(negedge avm_clk) begin
        logic [31:0] r;
        logic [8:0]  e;
        logic [27:0] x;
        if (!avm_rst) begin
            rx_q.delete();
            exp_q.delete();
            notready_left   = 0;
            force_rx_skip   = -1;
            in_xfer         = 1'b0;
            sv_exp          = 1'b0;
            fin_exp         = 1'b0;
            avm_waitrequest = 1'b0;
        end else begin
            check("store_valid", store_valid, sv_exp);
            check("store_finish", store_finish, fin_exp);
            if (store_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_store", 1'b1, 1'b0);
                end else begin
                    x = exp_q.pop_front();
                    check("addr_store", addr_store, x[27:8]);
                    check("pixel_value", pixel_value, x[7:0]);
                    check("img_idx", img_idx, x[27:8] / PPI);
                    if (x[27:8] == TOTAL - 1) fin_exp = 1'b1;
                end
            end
            sv_exp = 1'b0;

            if (in_xfer) begin
                check("read_held", avm_read, 1'b1);
                check("addr_held", avm_address, xfer_addr);
                if (!avm_read) in_xfer = 1'b0;
            end else if (avm_read) begin
                in_xfer   = 1'b1;
                xfer_addr = avm_address;
                wait_left = $urandom_range(0, 2);
                if (avm_address == RX_BASE) begin
                    if (force_rx_skip == 0) begin
                        wait_left     = 7;
                        force_rx_skip = -1;
                    end else if (force_rx_skip > 0) begin
                        force_rx_skip--;
                    end
                end
            end

            if (in_xfer) begin
                if (wait_left > 0) begin
                    wait_left--;
                    avm_waitrequest = 1'b1;
                    avm_readdata    = $urandom;
                end else begin
                    in_xfer         = 1'b0;
                    avm_waitrequest = 1'b0;
                    r               = $urandom;
                    if (xfer_addr == STATUS_BASE) begin
                        r[RX_OK_BIT] = (notready_left == 0) && (rx_q.size() > 0);
                        if (notready_left > 0) notready_left--;
                    end else if (xfer_addr == RX_BASE) begin
                        e = (rx_q.size() > 0) ? rx_q.pop_front() : 9'h000;
                        r[7:0] = e[7:0];
                        sv_exp = e[8];
                    end
                    avm_readdata = r;
                end
            end else begin
                avm_waitrequest = 1'($urandom_range(0, 1));
                avm_readdata    = $urandom;
            end
        end
    end

    function automatic logic [7:0] rand_garbage();
        logic [7:0] b;
        b = 8'($urandom_range(0, 254));
        if (b >= 8'hA5) b = b + 8'd1;
        return b;
    endfunction

    // mode 0: ramp from base, 1: all sync-valued pixels, 2: random
    task automatic push_image(input int img, input int n_garbage, input int mode, input logic [7:0] base);
        logic [7:0] p;
        for (int i = 0; i < n_garbage; i++) rx_q.push_back({1'b0, rand_garbage()});
        rx_q.push_back({1'b0, 8'hA5});
        for (int i = 0; i < PPI; i++) begin
            case (mode)
                0:       p = base + 8'(i);
                1:       p = 8'hA5;
                default: p = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
            endcase
            rx_q.push_back({1'b1, p});
            exp_q.push_back({20'(img * PPI + i), p});
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rx_q.size() != 0) && n < budget) begin
            @(posedge avm_clk);
            n++;
        end
        check("drain_timeout", n < budget, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_address"}, avm_address, STATUS_BASE);
        check({tag, "_read"}, avm_read, 1'b0);
        check({tag, "_pixel"}, pixel_value, 8'h00);
        check({tag, "_addr"}, addr_store, 20'h0);
        check({tag, "_valid"}, store_valid, 1'b0);
        check({tag, "_img"}, img_idx, 2'd0);
        check({tag, "_finish"}, store_finish, 1'b0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge avm_clk);
        #1;
        check_reset_outputs("rst");
        @(negedge avm_clk);
        #1 avm_rst = 1'b1;
        @(negedge avm_clk);
        check("first_read", avm_read, 1'b1);
        check("first_addr", avm_address, STATUS_BASE);

        // Image 0: slow status, two junk bytes before sync, ramp pixels.
        #1;
        notready_left = 5;
        rx_q.push_back({1'b0, 8'h00});
        rx_q.push_back({1'b0, 8'h55});
        push_image(0, 0, 0, 8'h10);
        wait_drain(2000);
        repeat (2) @(negedge avm_clk);
        check("img_idx_after_img0", img_idx, 2'd1);
        check("finish_after_img0", store_finish, 1'b0);

        // Image 1: sync-valued pixels, one RX read stalled for 7 cycles.
        #1;
        force_rx_skip = 3;
        push_image(1, $urandom_range(0, 2), 1, 8'h00);
        wait_drain(2000);
        repeat (2) @(negedge avm_clk);
        check("finish_after_all", store_finish, 1'b1);
        #1;
        for (int i = 0; i < 4; i++) rx_q.push_back({1'b0, 8'hA5});
        for (int i = 0; i < 20; i++) begin
            @(negedge avm_clk);
            check("idle_after_done", avm_read, 1'b0);
        end
        check("rx_untouched", rx_q.size(), 4);
        check("hold_pixel", pixel_value, 8'hA5);
        check("hold_addr", addr_store, 20'(TOTAL - 1));

        // Reset partway through a fresh transfer, after address 5 is stored.
        @(negedge avm_clk);
        #1 avm_rst = 1'b0;
        repeat (3) @(negedge avm_clk);
        #1 avm_rst = 1'b1;
        notready_left = $urandom_range(0, 3);
        push_image(0, $urandom_range(0, 3), 2, 8'h00);
        n = 0;
        while (exp_q.size() > PPI - 6 && n < 2000) begin
            @(negedge avm_clk);
            n++;
        end
        check("partial_timeout", n < 2000, 1'b1);
        #1 avm_rst = 1'b0;
        repeat (3) @(negedge avm_clk);
        check_reset_outputs("midrst");
        #1 avm_rst = 1'b1;
        notready_left = $urandom_range(0, 4);
        push_image(0, $urandom_range(0, 3), 2, 8'h00);
        push_image(1, $urandom_range(0, 3), 2, 8'h00);
        wait_drain(4000);
        repeat (2) @(negedge avm_clk);
        check("finish_after_restart", store_finish, 1'b1);
        check("img_idx_final", img_idx, 2'd1);
        check("read_idle_final", avm_read, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
